// File: rtl/adder_pkg.sv
// Shared types and defaults for the registered ripple-carry adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adder_pkg;

  localparam int ADDER_WIDTH_DEFAULT = 8;

  typedef enum logic {
    MODE_HALF = 1'b0,
    MODE_FULL = 1'b1
  } mode_e;

  // Carry fed into bit 0: half-add drops the incoming carry entirely
  function automatic logic effective_carry(input mode_e mode, input logic carry_in);
    return (mode == MODE_FULL) ? carry_in : 1'b0;
  endfunction

endpackage

// File: rtl/adder_unit_fa_cell.sv
// One-bit full adder cell, the only building block of the carry chain.
// Latency: purely combinational.
// Backpressure: none.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  // Propagate term shared by the sum and the carry
  logic p;

  assign p  = x ^ y;
  assign s  = p ^ ci;
  assign co = (x & y) | (ci & p);

endmodule

// File: rtl/adder_unit.sv
// Registered ripple-carry adder with half/full mode, signed overflow flag.
// Latency: 1 cycle from in_valid to out_valid, one operation per cycle.
// Backpressure: none; each valid input overwrites the held result.
module adder_unit
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  // c[i] is the carry into bit i; c[WIDTH] leaves the MSB
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_comb;
  logic             ovf_comb;

  assign c[0] = effective_carry(mode_e'(mode), carry_in);

  // Chain WIDTH full-adder cells; half-add comes purely from c[0] being 0
  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    fa_cell u_fa (
      .x  (a[i]),
      .y  (b[i]),
      .ci (c[i]),
      .s  (s_comb[i]),
      .co (c[i+1])
    );
  end

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  // For WIDTH=1 the carry into the MSB is the effective carry-in itself.
  assign ovf_comb = c[WIDTH-1] ^ c[WIDTH];

  // Result registers: capture only on valid so idle X on a/b never lands here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum       <= s_comb;
        carry_out <= c[WIDTH];
        overflow  <= ovf_comb;
      end
    end
  end

endmodule

// File: tb/tb_adder_unit.sv
// Self-checking bench for adder_unit at WIDTH=1 and WIDTH=8.
// Inputs change on the falling edge; outputs are compared on the falling edge.
// Expected values come from integer addition and the sign rule for overflow.
module tb_adder_unit;

  typedef struct {
    logic       v;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       v1, m1, ci1;
  logic [0:0] a1, b1;
  logic       ov1_vld, co1, ovf1;
  logic [0:0] s1;

  logic       v8, m8, ci8;
  logic [7:0] a8, b8;
  logic       ov8_vld, co8, ovf8;
  logic [7:0] s8;

  res_t exp1, exp8;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  adder_unit #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .mode(m1), .a(a1), .b(b1),
    .carry_in(ci1), .out_valid(ov1_vld), .sum(s1), .carry_out(co1), .overflow(ovf1)
  );

  adder_unit #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .mode(m8), .a(a8), .b(b8),
    .carry_in(ci8), .out_valid(ov8_vld), .sum(s8), .carry_out(co8), .overflow(ovf8)
  );

  // Reference: plain integer add, overflow from operand/result signs
  function automatic res_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                 input logic m, input logic ci);
    res_t        r;
    int unsigned total;
    int unsigned mask;
    total  = int'(a) + int'(b) + ((m && ci) ? 1 : 0);
    mask   = (32'd1 << w) - 1;
    r.v    = 1'b1;
    r.s    = 8'(total & mask);
    r.co   = ((total >> w) & 1) != 0;
    r.ov   = (a[w-1] == b[w-1]) && (r.s[w-1] != a[w-1]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".w1.vld"}, 64'(ov1_vld), 64'(exp1.v));
    chk({tag, ".w1.sum"}, 64'(s1),      64'(exp1.s[0]));
    chk({tag, ".w1.co"},  64'(co1),     64'(exp1.co));
    chk({tag, ".w1.ovf"}, 64'(ovf1),    64'(exp1.ov));
    chk({tag, ".w8.vld"}, 64'(ov8_vld), 64'(exp8.v));
    chk({tag, ".w8.sum"}, 64'(s8),      64'(exp8.s));
    chk({tag, ".w8.co"},  64'(co8),     64'(exp8.co));
    chk({tag, ".w8.ovf"}, 64'(ovf8),    64'(exp8.ov));
  endtask

  task automatic clear_exp();
    exp1 = '{v: 1'b0, s: 8'h00, co: 1'b0, ov: 1'b0};
    exp8 = '{v: 1'b0, s: 8'h00, co: 1'b0, ov: 1'b0};
  endtask

  // Advance one clock: update expectations at the rising edge, compare at the falling edge
  task automatic cycle(input string tag);
    res_t r;
    @(posedge clk);
    if (!rst_n) begin
      clear_exp();
    end else begin
      exp1.v = v1;
      if (v1) begin
        r = model(1, {7'd0, a1}, {7'd0, b1}, m1, ci1);
        exp1 = r;
      end
      exp8.v = v8;
      if (v8) begin
        r = model(8, a8, b8, m8, ci8);
        exp8 = r;
      end
    end
    @(negedge clk);
    chk_all(tag);
  endtask

  task automatic drive1(input logic v, input logic m, input logic a, input logic b, input logic ci);
    v1 = v; m1 = m; a1 = a; b1 = b; ci1 = ci;
  endtask

  task automatic drive8(input logic v, input logic m, input logic [7:0] a,
                        input logic [7:0] b, input logic ci);
    v8 = v; m8 = m; ci8 = ci;
    if (v) begin a8 = a; b8 = b; end
    else   begin a8 = 'x; b8 = 'x; end
  endtask

  initial begin
    logic [1:0] tt [8];
    tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    // Reset state
    rst_n = 1'b0;
    drive1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    clear_exp();
    #2;
    chk_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 full-mode truth table, one combination per cycle
    for (int i = 0; i < 8; i++) begin
      logic [2:0] cab;
      cab = 3'(i);
      drive1(1'b1, 1'b1, cab[1], cab[0], cab[2]);
      cycle("tt");
      chk("tt.const", 64'({co1, s1}), 64'(tt[i]));
    end

    // WIDTH=1 half mode ignores carry_in
    drive1(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    cycle("half11");
    chk("half11.sum", 64'(s1), 64'd0);
    chk("half11.co",  64'(co1), 64'd1);
    drive1(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cycle("half01");
    chk("half01.sum", 64'(s1), 64'd1);
    chk("half01.co",  64'(co1), 64'd0);
    drive1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // WIDTH=8 wrap and signed overflow
    drive8(1'b1, 1'b1, 8'hFF, 8'h01, 1'b0);
    cycle("wrap");
    chk("wrap.const", 64'({ovf8, co8, s8}), 64'({1'b0, 1'b1, 8'h00}));
    drive8(1'b1, 1'b1, 8'h7F, 8'h00, 1'b1);
    cycle("ovf");
    chk("ovf.const", 64'({ovf8, co8, s8}), 64'({1'b1, 1'b0, 8'h80}));

    // Latency and hold with X on idle operands
    drive8(1'b1, 1'b0, 8'h12, 8'h34, 1'b1);
    cycle("lat");
    chk("lat.sum", 64'(s8), 64'h46);
    drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cycle("hold");
    chk("hold.sum", 64'(s8), 64'h46);
    cycle("hold2");

    // Asynchronous reset between edges while a result is valid
    drive8(1'b1, 1'b1, 8'hF0, 8'h20, 1'b1);
    drive1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    cycle("pre_rst");
    #2 rst_n = 1'b0;
    #1;
    clear_exp();
    chk_all("async_rst");
    cycle("rst_held");
    drive1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b1;
    cycle("post_rst");
    cycle("post_rst2");

    // Four back-to-back operations, no bubbles
    for (int i = 0; i < 4; i++) begin
      drive8(1'b1, 1'(i & 1), 8'(8'h41 * (i + 1)), 8'(8'h3C + 8'h29 * i), 1'b1);
      cycle("b2b");
    end
    drive8(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cycle("b2b_end");

    // Randomised traffic on both widths
    for (int i = 0; i < 300; i++) begin
      drive1(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      drive8(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
